inst_rom_arbiter: RTL and testbench
===================================

// Module: inst_rom_arbiter
// PURPOSE
//   Shares the single combinational instruction ROM between the IF stage and a debug/loader
//   read-burst port. IF has priority; a starvation counter forces one debug access after
//   MAX_WAIT consecutive IF grants while a burst is pending. Read data is registered, so
//   responses arrive one cycle after grant. Sits between pc_reg/if_id, ctrl and the ROM.
// PARAMETERS
//   ADDR_W    32  address width (byte address, word aligned)
//   DATA_W    32  instruction word width
//   MAX_WAIT  4   consecutive IF grants tolerated while DBG pending (>=1)
//   LEN_W     8   width of burst length field
// PORTS
//   clk           in   1       clock, rising edge
//   rst           in   1       synchronous reset, active high
//   if_req        in   1       IF fetch request this cycle
//   if_addr       in   ADDR_W  IF fetch address (pc)
//   if_inst       out  DATA_W  registered instruction for IF
//   if_valid      out  1       if_inst valid (pulse, 1 cycle after IF grant)
//   stallreq_arb  out  1       to ctrl: IF requested but not granted this cycle
//   dbg_start     in   1       start debug burst (sampled only when idle)
//   dbg_addr      in   ADDR_W  burst base address; bits[1:0] forced to 0
//   dbg_len       in   LEN_W   burst word count; 0 = ignored
//   dbg_busy      out  1       burst in progress
//   dbg_data      out  DATA_W  registered burst word
//   dbg_valid     out  1       dbg_data valid (pulse per word)
//   dbg_done      out  1       pulse together with dbg_valid of last word
//   rom_ce        out  1       ROM chip enable
//   rom_addr      out  ADDR_W  ROM address
//   rom_inst      in   DATA_W  ROM read data (combinational from rom_addr)
// BEHAVIOUR
//   - Reset: state S_IDLE; wait_cnt, dbg_ptr, remaining = 0; all registered outputs 0.
//     rst mid-burst aborts it: no dbg_done, no further dbg_valid.
//   - FSM: S_IDLE -> S_BURST when dbg_start & dbg_len!=0 (latch dbg_ptr={dbg_addr[ADDR_W-1:2],2'b00},
//     remaining=dbg_len). S_BURST -> S_IDLE on the cycle the last word is granted.
//     dbg_start in S_BURST or with dbg_len==0 is ignored. dbg_busy = (state==S_BURST).
//   - Grant (combinational, one-hot or none):
//     dbg_pend = S_BURST. gnt_dbg = dbg_pend & (~if_req | wait_cnt==MAX_WAIT);
//     gnt_if = if_req & ~gnt_dbg.
//   - ROM drive: rom_ce = gnt_if|gnt_dbg; rom_addr = gnt_if ? if_addr : gnt_dbg ? dbg_ptr : 0.
//   - stallreq_arb = if_req & ~gnt_if (combinational, same cycle).
//   - wait_cnt: +1 when gnt_if & dbg_pend (saturate at MAX_WAIT); cleared on gnt_dbg or S_IDLE.
//   - Next edge after gnt_if: if_inst<=rom_inst, if_valid<=1; else if_valid<=0, if_inst holds.
//   - Next edge after gnt_dbg: dbg_data<=rom_inst, dbg_valid<=1, dbg_ptr+=4 (wraps mod 2^ADDR_W),
//     remaining-=1; dbg_done<=1 iff remaining was 1. Otherwise dbg_valid, dbg_done <= 0.
//   - Latency: 1 cycle grant->valid for both ports; no internal buffering beyond one word each.
//   - dbg_start in the same cycle the burst ends is ignored (state still S_BURST).
// TESTING
//   1. if_req=1, if_addr 0x0,0x4,0x8 on successive cycles, no burst -> rom_addr follows,
//      if_valid high cycles 2-4 with matching words, stallreq_arb stays 0.
//   2. if_req=0, dbg_start addr=0x100 len=3 -> rom_addr 0x100,0x104,0x108 on 3 consecutive
//      cycles, dbg_valid 3 cycles, dbg_done with 3rd, dbg_busy low after.
//   3. MAX_WAIT=4, if_req held 1, burst len=2 -> grants IF x4, DBG, IF x4, DBG; stallreq_arb
//      high exactly on DBG cycles; if_valid low the cycle after each DBG grant.
//   4. dbg_start with len=0 -> dbg_busy stays 0; dbg_start during active burst -> ignored,
//      original burst word count unchanged.
//   5. rst asserted in 2nd word of len=4 burst -> next cycle dbg_busy/valid/done=0, if_valid=0;
//      subsequent burst len=1 at 0x40 completes normally.
//   6. Wrap: dbg_addr=0xFFFFFFFE len=2 -> rom_addr 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the shared combinational instruction ROM between IF fetches and a debug
// read-burst port; IF wins except when a pending burst has waited MAX_WAIT IF grants.
module inst_rom_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              stallreq_arb,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [LEN_W-1:0]  dbg_len,
  output logic              dbg_busy,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  output logic              dbg_done,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam int WC_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        state;
  logic [WC_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0] dbg_ptr;
  logic [LEN_W-1:0]  remaining;

  logic dbg_pend;
  logic gnt_dbg;
  logic gnt_if;
  logic last_word;

  // Grant decision: one-hot or none, resolved in the request cycle
  always_comb begin
    dbg_pend  = (state == S_BURST);
    gnt_dbg   = dbg_pend & (~if_req | (wait_cnt == WAIT_MAX));
    gnt_if    = if_req & ~gnt_dbg;
    last_word = gnt_dbg & (remaining == LEN_W'(1));
  end

  always_comb begin
    rom_ce       = gnt_if | gnt_dbg;
    rom_addr     = '0;
    if (gnt_if)
      rom_addr = if_addr;
    else if (gnt_dbg)
      rom_addr = dbg_ptr;
    stallreq_arb = if_req & ~gnt_if;
    dbg_busy     = dbg_pend;
  end

  // Burst control: a start is only honoured from idle with a nonzero length
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dbg_ptr   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dbg_start && (dbg_len != '0)) begin
            state     <= S_BURST;
            dbg_ptr   <= {dbg_addr[ADDR_W-1:2], 2'b00};
            remaining <= dbg_len;
          end
        end
        default: begin
          if (gnt_dbg) begin
            dbg_ptr   <= dbg_ptr + ADDR_W'(4);
            remaining <= remaining - LEN_W'(1);
            if (last_word)
              state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Starvation counter only advances while a burst is actually waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (gnt_dbg || !dbg_pend) begin
      wait_cnt <= '0;
    end else if (gnt_if && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WC_W'(1);
    end
  end

  // Response stage: ROM word captured one cycle after its grant
  always_ff @(posedge clk) begin
    if (rst) begin
      if_inst   <= '0;
      if_valid  <= 1'b0;
      dbg_data  <= '0;
      dbg_valid <= 1'b0;
      dbg_done  <= 1'b0;
    end else begin
      if_valid  <= gnt_if;
      if (gnt_if)
        if_inst <= rom_inst;
      dbg_valid <= gnt_dbg;
      dbg_done  <= last_word;
      if (gnt_dbg)
        dbg_data <= rom_inst;
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter with a combinational ROM model driven from rom_addr.
module tb_inst_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stallreq_arb;
  logic        dbg_start;
  logic [31:0] dbg_addr;
  logic [7:0]  dbg_len;
  logic        dbg_busy;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic        dbg_done;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[31:16], a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .stallreq_arb(stallreq_arb),
    .dbg_start(dbg_start), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
    .dbg_busy(dbg_busy), .dbg_data(dbg_data), .dbg_valid(dbg_valid), .dbg_done(dbg_done),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ia;
    logic [31:0] da;
    bit          exp_dbg;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dbg_start = 1'b0; dbg_addr = '0; dbg_len = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_dbg_busy", dbg_busy, 0);
    chk("rst_dbg_valid", dbg_valid, 0);
    chk("rst_dbg_done", dbg_done, 0);
    chk("rst_dbg_data", dbg_data, 0);
    chk("rst_rom_ce", rom_ce, 0);

    // 1: plain IF fetches
    if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_addr = 32'(i * 4);
      #1;
      chk("t1_rom_addr", rom_addr, 32'(i * 4));
      chk("t1_stall", stallreq_arb, 0);
      tick();
      chk("t1_if_valid", if_valid, 1);
      chk("t1_if_inst", if_inst, rom_word(32'(i * 4)));
    end
    if_req = 1'b0;
    tick();
    chk("t1_if_valid_off", if_valid, 0);
    chk("t1_if_inst_hold", if_inst, rom_word(32'h8));

    // 2: debug burst with IF idle
    dbg_start = 1'b1; dbg_addr = 32'h100; dbg_len = 8'd3;
    #1;
    chk("t2_no_grant_idle", rom_ce, 0);
    tick();
    dbg_start = 1'b0;
    chk("t2_busy", dbg_busy, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_rom_addr", rom_addr, 32'h100 + 32'(i * 4));
      chk("t2_stall", stallreq_arb, 0);
      tick();
      chk("t2_dbg_valid", dbg_valid, 1);
      chk("t2_dbg_data", dbg_data, rom_word(32'h100 + 32'(i * 4)));
      chk("t2_dbg_done", dbg_done, (i == 2));
    end
    chk("t2_busy_after", dbg_busy, 0);
    tick();
    chk("t2_valid_after", dbg_valid, 0);

    // 3: starvation forcing with IF held
    if_req = 1'b1; if_addr = 32'h200;
    dbg_start = 1'b1; dbg_addr = 32'h300; dbg_len = 8'd2;
    tick();
    dbg_start = 1'b0;
    chk("t3_start_if_valid", if_valid, 1);
    ia = 32'h204; da = 32'h300;
    for (int c = 0; c < 10; c++) begin
      exp_dbg = (c == 4) || (c == 9);
      if_addr = ia;
      #1;
      chk("t3_stall", stallreq_arb, exp_dbg);
      chk("t3_rom_addr", rom_addr, exp_dbg ? da : ia);
      tick();
      chk("t3_if_valid", if_valid, !exp_dbg);
      chk("t3_dbg_valid", dbg_valid, exp_dbg);
      if (exp_dbg) begin
        chk("t3_dbg_data", dbg_data, rom_word(da));
        da += 4;
      end else begin
        chk("t3_if_inst", if_inst, rom_word(ia));
        ia += 4;
      end
    end
    chk("t3_done", dbg_done, 1);
    chk("t3_busy_after", dbg_busy, 0);
    if_req = 1'b0;

    // 4: zero length ignored; start during burst ignored
    dbg_start = 1'b1; dbg_addr = 32'h400; dbg_len = 8'd0;
    tick();
    chk("t4_len0_busy", dbg_busy, 0);
    dbg_len = 8'd2;
    tick();
    chk("t4_busy", dbg_busy, 1);
    dbg_addr = 32'h800; dbg_len = 8'd5;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_rom_addr", rom_addr, 32'h400 + 32'(i * 4));
      tick();
      chk("t4_dbg_done", dbg_done, (i == 1));
    end
    dbg_start = 1'b0;
    chk("t4_busy_after", dbg_busy, 0);
    tick();
    chk("t4_no_extra_valid", dbg_valid, 0);

    // 5: reset aborts a burst mid-way
    dbg_start = 1'b1; dbg_addr = 32'h500; dbg_len = 8'd4;
    tick();
    dbg_start = 1'b0;
    tick();
    chk("t5_word1_valid", dbg_valid, 1);
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h600;
    tick();
    rst = 1'b0; if_req = 1'b0;
    chk("t5_busy", dbg_busy, 0);
    chk("t5_valid", dbg_valid, 0);
    chk("t5_done", dbg_done, 0);
    chk("t5_if_valid", if_valid, 0);
    dbg_start = 1'b1; dbg_addr = 32'h40; dbg_len = 8'd1;
    tick();
    dbg_start = 1'b0;
    #1;
    chk("t5_rom_addr", rom_addr, 32'h40);
    tick();
    chk("t5_valid2", dbg_valid, 1);
    chk("t5_done2", dbg_done, 1);
    chk("t5_data2", dbg_data, rom_word(32'h40));
    chk("t5_busy2", dbg_busy, 0);

    // 6: address alignment and wrap
    dbg_start = 1'b1; dbg_addr = 32'hFFFF_FFFE; dbg_len = 8'd2;
    tick();
    dbg_start = 1'b0;
    #1;
    chk("t6_addr0", rom_addr, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("t6_addr1", rom_addr, 32'h0000_0000);
    tick();
    chk("t6_done", dbg_done, 1);
    chk("t6_data", dbg_data, rom_word(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
